// File: rtl/output_port_mc_if.sv
// User-side stream bundle for output_port_mc: one packed data bus plus
// per-channel valid/ready, one lane per channel.
interface output_port_mc_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int PAYLOAD_BITS = 64
);
    // Handshake: a word on channel c transfers in any cycle where
    // vld_user2b_out[c] and ack_b_out2user[c] are both high. ack never
    // depends on vld, and a vld while ack is low is dropped, not held.
    logic [NUM_CHANNELS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_CHANNELS-1:0]              vld_user2b_out;
    logic [NUM_CHANNELS-1:0]              ack_b_out2user;

    modport master (
        output din_leaf_user2interface,
        output vld_user2b_out,
        input  ack_b_out2user
    );

    modport slave (
        input  din_leaf_user2interface,
        input  vld_user2b_out,
        output ack_b_out2user
    );
endinterface

// File: rtl/output_port_mc.sv
// Multi-channel BFT leaf output port: per-channel FIFOs, credit tracking and
// a round-robin arbiter emitting one network packet per grant.
module output_port_mc #(
    parameter int PACKET_BITS           = 97,
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int NUM_CHANNELS          = 4,
    parameter int FIFO_DEPTH_BITS       = 5,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    localparam int CH_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CH_BITS-1:0]       cfg_chan,
    input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] dst_port,
    input  logic [NUM_ADDR_BITS-1:0] fifo_addr,
    input  logic [NUM_ADDR_BITS-1:0] freespace,
    input  logic                     update_freespace_en,
    input  logic                     update_fifo_addr_en,
    input  logic                     add_freespace_en,
    input  logic                     rd_en_sel,
    output logic [PACKET_BITS-1:0]   internal_out,
    output logic                     empty,
    output_port_mc_if.slave          user
);
    localparam int DEPTH      = 2 ** FIFO_DEPTH_BITS;
    localparam int MAX_CREDIT = 2 ** NUM_ADDR_BITS - 1;

    logic [PAYLOAD_BITS-1:0]  mem      [NUM_CHANNELS][DEPTH];
    logic [FIFO_DEPTH_BITS:0] wr_ptr   [NUM_CHANNELS];
    logic [FIFO_DEPTH_BITS:0] rd_ptr   [NUM_CHANNELS];
    logic [NUM_ADDR_BITS-1:0] free_cnt [NUM_CHANNELS];
    logic [NUM_ADDR_BITS-1:0] free_next[NUM_CHANNELS];
    logic [NUM_ADDR_BITS-1:0] addr_reg [NUM_CHANNELS];
    logic [NUM_LEAF_BITS-1:0] leaf_reg [NUM_CHANNELS];
    logic [NUM_PORT_BITS-1:0] port_reg [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] fifo_empty, fifo_full, push, pop, eligible;
    logic [CH_BITS-1:0]      rr_ptr, gnt_chan, scan_idx, out_chan;
    logic                    found, grant, out_valid;
    logic [PAYLOAD_BITS-1:0] out_data;
    logic [31:0]             credit_sum;

    // Full is judged on pre-pop occupancy, so a push into a full FIFO is
    // refused even when that FIFO is popped in the same cycle.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]);
            fifo_full[c]  = (wr_ptr[c][FIFO_DEPTH_BITS] != rd_ptr[c][FIFO_DEPTH_BITS]) &&
                            (wr_ptr[c][FIFO_DEPTH_BITS-1:0] == rd_ptr[c][FIFO_DEPTH_BITS-1:0]);
            push[c]       = user.vld_user2b_out[c] & ~fifo_full[c];
            eligible[c]   = ~fifo_empty[c] & (free_cnt[c] != '0);
        end
    end

    always_comb begin
        found    = 1'b0;
        gnt_chan = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            scan_idx = CH_BITS'((int'(rr_ptr) + i) % NUM_CHANNELS);
            if (!found && eligible[scan_idx]) begin
                found    = 1'b1;
                gnt_chan = scan_idx;
            end
        end
        grant = rd_en_sel & found;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            pop[c] = grant && (gnt_chan == CH_BITS'(c));
        end
    end

    // Credit update; a returned batch saturates at the counter maximum.
    always_comb begin
        credit_sum = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            free_next[c] = free_cnt[c];
            if (update_freespace_en && cfg_chan == CH_BITS'(c)) begin
                free_next[c] = freespace;
            end else if (add_freespace_en && cfg_chan == CH_BITS'(c)) begin
                credit_sum = 32'(free_cnt[c]) + 32'(FREESPACE_UPDATE_SIZE) - {31'd0, pop[c]};
                if (credit_sum > 32'(MAX_CREDIT)) begin
                    free_next[c] = NUM_ADDR_BITS'(MAX_CREDIT);
                end else begin
                    free_next[c] = NUM_ADDR_BITS'(credit_sum);
                end
            end else if (pop[c]) begin
                free_next[c] = free_cnt[c] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c][FIFO_DEPTH_BITS-1:0]] <=
                    user.din_leaf_user2interface[c*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wr_ptr[c]   <= '0;
                rd_ptr[c]   <= '0;
                free_cnt[c] <= NUM_ADDR_BITS'(MAX_CREDIT);
                addr_reg[c] <= '0;
                leaf_reg[c] <= '0;
                port_reg[c] <= '0;
            end
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                free_cnt[c] <= free_next[c];
                // A config load beats the post-emission address increment.
                if (update_fifo_addr_en && cfg_chan == CH_BITS'(c)) begin
                    addr_reg[c] <= fifo_addr;
                    leaf_reg[c] <= dst_leaf;
                    port_reg[c] <= dst_port;
                end else if (out_valid && out_chan == CH_BITS'(c)) begin
                    addr_reg[c] <= addr_reg[c] + 1'b1;
                end
            end
            out_valid <= grant;
            if (grant) begin
                out_chan <= gnt_chan;
                out_data <= mem[gnt_chan][rd_ptr[gnt_chan][FIFO_DEPTH_BITS-1:0]];
                rr_ptr   <= CH_BITS'((int'(gnt_chan) + 1) % NUM_CHANNELS);
            end
        end
    end

    always_comb begin
        internal_out = '0;
        if (out_valid) begin
            internal_out[PACKET_BITS-1]                                = 1'b1;
            internal_out[PACKET_BITS-2 -: NUM_LEAF_BITS]               = leaf_reg[out_chan];
            internal_out[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS] = port_reg[out_chan];
            internal_out[PAYLOAD_BITS +: NUM_ADDR_BITS]                = addr_reg[out_chan];
            internal_out[PAYLOAD_BITS-1:0]                             = out_data;
        end
    end

    assign empty               = &fifo_empty;
    assign user.ack_b_out2user = ~fifo_full;
endmodule
